// File: rtl/tx_inband_pkg.sv
// Shared definitions for the TX in-band packet path: the header field position,
// default packet geometry and the router FSM encoding. cmd_reader and
// chan_fifo_reader use these as well.
package tx_inband_pkg;

  // Channel-select field inside the header word.
  localparam int CHAN_FIELD_HI = 20;
  localparam int CHAN_FIELD_LO = 16;

  // Channel field value that selects the command RAM.
  localparam logic [4:0] CMD_ID_DEFAULT = 5'h1F;

  // 32-bit words per packet, header included (512-byte packets).
  localparam int PKT_WORDS_DEFAULT = 128;

  // Router FSM encoding, visible on the debug bus.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } rt_state_t;

endpackage

// File: rtl/tx_packet_router_sat_counter.sv
// Event counter with a choice of saturating or wrapping behaviour.
module sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             txclk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count one per inc pulse; in saturate mode stick at all-ones.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      if (SATURATE && (&count)) count <= count;
      else                      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tx_packet_router.sv
// Routes whole packets from the USB packer to one of NUM_CHAN data RAMs or to
// the command RAM, selected by the channel field of each packet's header word.
// Packets for unknown channels or for RAMs without space are swallowed and
// counted.
//
// Handshake: WR_final is a valid-only strobe with no ready/backpressure. A word
// is accepted on every rising edge of txclk where WR_final is high; when it is
// low nothing advances. Space is therefore checked once, at the header, and
// the whole packet is then committed to its destination.
module tx_packet_router
  import tx_inband_pkg::*;
#(
  parameter int         NUM_CHAN  = 2,
  parameter int         PKT_WORDS = PKT_WORDS_DEFAULT,
  parameter logic [4:0] CMD_ID    = CMD_ID_DEFAULT
) (
  input  logic                txclk,
  input  logic                reset,
  input  logic [31:0]         usbdata_final,
  input  logic                WR_final,
  input  logic [NUM_CHAN:0]   chan_have_space,
  input  logic [NUM_CHAN-1:0] chan_txempty,
  output logic [31:0]         ram_data,
  output logic [NUM_CHAN:0]   WR_channel,
  output logic [NUM_CHAN:0]   WR_done_channel,
  output logic                have_space,
  output logic                tx_empty,
  output logic [15:0]         drop_count,
  output logic [15:0]         pkt_count,
  output logic [1:0]          state
);

  localparam int NR = NUM_CHAN + 1;
  localparam int CW = $clog2(PKT_WORDS);
  localparam int DW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

  rt_state_t      st;
  logic [CW-1:0]  wcnt;
  logic [DW-1:0]  dst;
  logic [4:0]     hdr_ch;
  logic           hdr_hit;
  logic [DW-1:0]  hdr_dst;
  logic           last_word;
  logic           pkt_inc;
  logic           drop_inc;

  assign hdr_ch = usbdata_final[CHAN_FIELD_HI:CHAN_FIELD_LO];

  // Header decode: a data channel with space, else the command RAM with space.
  always_comb begin
    hdr_hit = 1'b0;
    hdr_dst = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (!hdr_hit && (hdr_ch == 5'(i)) && chan_have_space[i]) begin
        hdr_hit = 1'b1;
        hdr_dst = DW'(i);
      end
    end
    if (!hdr_hit && (hdr_ch == CMD_ID) && chan_have_space[NUM_CHAN]) begin
      hdr_hit = 1'b1;
      hdr_dst = DW'(NUM_CHAN);
    end
  end

  assign last_word  = WR_final && (st != ST_IDLE) && (wcnt == LAST_IDX);
  assign pkt_inc    = last_word && (st == ST_FWD);
  assign drop_inc   = last_word && (st == ST_DROP);
  assign have_space = &chan_have_space;
  assign tx_empty   = &chan_txempty;
  assign state      = st;

  // Packet FSM with registered data, write strobes and end-of-packet strobes.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      st              <= ST_IDLE;
      wcnt            <= '0;
      dst             <= '0;
      ram_data        <= '0;
      WR_channel      <= '0;
      WR_done_channel <= '0;
    end else begin
      WR_channel      <= '0;
      WR_done_channel <= '0;
      if (WR_final) begin
        case (st)
          ST_IDLE: begin
            wcnt <= CW'(1);
            if (hdr_hit) begin
              dst        <= hdr_dst;
              ram_data   <= usbdata_final;
              WR_channel <= NR'(1) << hdr_dst;
              st         <= ST_FWD;
            end else begin
              st <= ST_DROP;
            end
          end
          ST_FWD: begin
            ram_data   <= usbdata_final;
            WR_channel <= NR'(1) << dst;
            if (last_word) begin
              WR_done_channel <= NR'(1) << dst;
              wcnt            <= '0;
              st              <= ST_IDLE;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
          ST_DROP: begin
            if (last_word) begin
              wcnt <= '0;
              st   <= ST_IDLE;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_drop_cnt (
    .txclk (txclk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_count)
  );

  sat_counter #(.WIDTH(16), .SATURATE(1'b0)) u_pkt_cnt (
    .txclk (txclk),
    .reset (reset),
    .inc   (pkt_inc),
    .count (pkt_count)
  );

endmodule

// File: tb/tb_tx_packet_router.sv
// Bench for tx_packet_router (NUM_CHAN=4, short packets) plus a direct look at
// sat_counter saturation and wrap, which the 16-bit packet counters cannot
// reach in a short run.
module tb_tx_packet_router;

  localparam int         NC  = 4;
  localparam int         PW  = 16;
  localparam logic [4:0] CMD = 5'h1F;

  // ---------------- clock / reset ----------------
  logic        txclk = 1'b0;
  logic        reset;
  logic [31:0] usbdata_final;
  logic        WR_final;
  logic [NC:0] chan_have_space;
  logic [NC-1:0] chan_txempty;
  logic [31:0] ram_data;
  logic [NC:0] WR_channel;
  logic [NC:0] WR_done_channel;
  logic        have_space;
  logic        tx_empty;
  logic [15:0] drop_count;
  logic [15:0] pkt_count;
  logic [1:0]  state;
  logic        sc_inc;
  logic [3:0]  sat_cnt;
  logic [3:0]  wrap_cnt;

  always #5 txclk = ~txclk;

  tx_packet_router #(.NUM_CHAN(NC), .PKT_WORDS(PW), .CMD_ID(CMD)) dut (
    .txclk           (txclk),
    .reset           (reset),
    .usbdata_final   (usbdata_final),
    .WR_final        (WR_final),
    .chan_have_space (chan_have_space),
    .chan_txempty    (chan_txempty),
    .ram_data        (ram_data),
    .WR_channel      (WR_channel),
    .WR_done_channel (WR_done_channel),
    .have_space      (have_space),
    .tx_empty        (tx_empty),
    .drop_count      (drop_count),
    .pkt_count       (pkt_count),
    .state           (state)
  );

  sat_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .txclk (txclk), .reset (reset), .inc (sc_inc), .count (sat_cnt)
  );

  sat_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .txclk (txclk), .reset (reset), .inc (sc_inc), .count (wrap_cnt)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected write: {done, destination index, data word}.
  logic [35:0] exp_q[$];
  logic [15:0] exp_pkt  = '0;
  logic [15:0] exp_drop = '0;
  int          wr_run     = 0;
  int          wr_run_max = 0;

  // Scoreboard: every strobe cycle must match the next expected write.
  always @(negedge txclk) begin
    if (WR_channel != '0 || WR_done_channel != '0) begin
      wr_run++;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
      if (exp_q.size() == 0) begin
        check_val("spurious_wr", 32'(WR_channel), 32'd0);
      end else begin
        logic [35:0] e;
        logic [4:0]  eoh;
        e   = exp_q.pop_front();
        eoh = 5'(1) << e[34:32];
        check_val("wr_channel", 32'(WR_channel), 32'(eoh));
        check_val("wr_done", 32'(WR_done_channel), e[35] ? 32'(eoh) : 32'd0);
        check_val("ram_data", ram_data, e[31:0]);
      end
    end else begin
      wr_run = 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_word(input logic [31:0] d, input int gapmax);
    int g;
    g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    repeat (g) begin
      @(posedge txclk); #1;
      WR_final = 1'b0;
    end
    @(posedge txclk); #1;
    WR_final      = 1'b1;
    usbdata_final = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge txclk); #1;
      WR_final = 1'b0;
    end
  endtask

  // Packet-level model: the routing decision is made once from the header and
  // the space flags present at that moment; later space changes are ignored.
  task automatic send_packet(input logic [4:0] ch, input int nwords, input int gapmax,
                             input bit rnd_space);
    logic [31:0] hdr;
    logic [31:0] d;
    logic        fwd;
    logic [2:0]  dst;
    hdr = $urandom;
    hdr[20:16] = ch;
    fwd = 1'b0;
    dst = '0;
    if (ch < 5'(NC) && chan_have_space[ch[2:0]]) begin
      fwd = 1'b1;
      dst = ch[2:0];
    end else if (ch == CMD && chan_have_space[NC]) begin
      fwd = 1'b1;
      dst = 3'(NC);
    end
    for (int k = 0; k < nwords; k++) begin
      d = (k == 0) ? hdr : $urandom;
      drive_word(d, gapmax);
      if (k == 1 && rnd_space) chan_have_space = 5'($urandom);
      if (fwd) exp_q.push_back({(k == PW - 1), dst, d});
    end
    if (nwords == PW) begin
      if (fwd) exp_pkt++;
      else if (exp_drop != 16'hFFFF) exp_drop++;
    end
  endtask

  task automatic check_counts(input string tag);
    @(negedge txclk); #1;
    check_val({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkt));
    check_val({tag, "_drop_count"}, 32'(drop_count), 32'(exp_drop));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    usbdata_final   = '0;
    WR_final        = 1'b0;
    chan_have_space = '1;
    chan_txempty    = '1;
    sc_inc          = 1'b0;
    repeat (3) @(posedge txclk);
    #1;
    check_val("rst_ram_data", ram_data, 32'd0);
    check_val("rst_wr", 32'(WR_channel), 32'd0);
    check_val("rst_done", 32'(WR_done_channel), 32'd0);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_pkt", 32'(pkt_count), 32'd0);
    check_val("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;

    // sat_counter: 20 increments on 4-bit counters.
    @(posedge txclk); #1;
    sc_inc = 1'b1;
    repeat (20) @(posedge txclk);
    #1;
    sc_inc = 1'b0;
    check_val("sat_hold", 32'(sat_cnt), 32'd15);
    check_val("wrap_mod", 32'(wrap_cnt), 32'd4);

    // Reductions.
    chan_have_space = 5'b11111; chan_txempty = 4'b1111; #1;
    check_val("have_space_all", 32'(have_space), 32'd1);
    check_val("tx_empty_all", 32'(tx_empty), 32'd1);
    chan_have_space = 5'b01111; chan_txempty = 4'b1011; #1;
    check_val("have_space_cmd0", 32'(have_space), 32'd0);
    check_val("tx_empty_one0", 32'(tx_empty), 32'd0);
    chan_have_space = '1; chan_txempty = '1;

    // Directed: data channel 1, then command RAM.
    send_packet(5'd1, PW, 0, 1'b0);
    idle(2);
    check_counts("ch1");
    check_val("ch1_pkt_is_1", 32'(pkt_count), 32'd1);
    send_packet(CMD, PW, 0, 1'b0);
    idle(2);
    check_counts("cmd");

    // Directed drops: unknown channel, then channel 0 without space.
    send_packet(5'd5, PW, 0, 1'b0);
    idle(1);
    chan_have_space = 5'b11110;
    send_packet(5'd0, PW, 0, 1'b0);
    idle(2);
    chan_have_space = '1;
    check_counts("drop");
    check_val("drop_is_2", 32'(drop_count), 32'd2);
    check_val("drop_idle", 32'(state), 32'd0);

    // Back-to-back packets with WR_final held high throughout.
    idle(3);
    wr_run_max = 0;
    send_packet(5'd0, PW, 0, 1'b0);
    send_packet(5'd1, PW, 0, 1'b0);
    idle(3);
    check_val("b2b_run", 32'(wr_run_max), 32'(2 * PW));
    check_counts("b2b");

    // Asynchronous reset in the middle of a forwarded packet.
    send_packet(5'd2, 9, 0, 1'b0);
    @(posedge txclk); #1;
    WR_final = 1'b0;
    @(negedge txclk); #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_wr", 32'(WR_channel), 32'd0);
    check_val("mid_rst_done", 32'(WR_done_channel), 32'd0);
    check_val("mid_rst_data", ram_data, 32'd0);
    check_val("mid_rst_state", 32'(state), 32'd0);
    check_val("mid_rst_pkt", 32'(pkt_count), 32'd0);
    exp_pkt  = '0;
    exp_drop = '0;
    #4;
    reset = 1'b0;
    send_packet(5'd3, PW, 0, 1'b0);
    idle(2);
    check_counts("post_rst");

    // Randomized packets with gaps and changing space flags.
    for (int p = 0; p < 1000; p++) begin
      int         r;
      logic [4:0] ch;
      r = $urandom_range(0, 9);
      if (r <= 5)      ch = 5'(r % NC);
      else if (r <= 7) ch = CMD;
      else             ch = 5'($urandom_range(NC, 30));
      chan_have_space = ($urandom_range(0, 3) != 0) ? '1 : 5'($urandom);
      chan_txempty    = 4'($urandom);
      #1;
      if (p % 50 == 0) begin
        check_val("rnd_have_space", 32'(have_space), 32'(&chan_have_space));
        check_val("rnd_tx_empty", 32'(tx_empty), 32'(&chan_txempty));
      end
      send_packet(ch, PW, 2, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        idle(2);
        check_counts("rnd");
      end
    end
    idle(4);
    check_counts("final");
    check_val("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
